// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - FIFO-buffered issue stage feeding shift_unit, with a registered result handshake.
// Optional SHIFT_ISSUE_STATS_EN adds a saturating issue_count port.
module shift_issue_stage #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_op1,
  input  logic [15:0]              in_op2,
  input  logic [2:0]               in_sel,
  output logic [31:0]              shift_in,
  output logic [2:0]               shift_lines,
  input  logic [31:0]              shift_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [2:0]               out_sel,
  output logic [$clog2(DEPTH):0]   fifo_level
`ifdef SHIFT_ISSUE_STATS_EN
  ,
  output logic [15:0]              issue_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef struct packed {
    logic [15:0] op1;
    logic [15:0] op2;
    logic [2:0]  sel;
  } entry_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  out_state_e    out_state_q, out_state_d;
  logic [31:0]   out_result_q, out_result_d;
  logic [2:0]    out_sel_q, out_sel_d;

  entry_t head;
  logic   fifo_empty;
  logic   push;
  logic   pop;

  // in_ready looks only at occupancy, so a full FIFO refuses a push even while popping.
  always_comb begin
    head        = mem_q[rd_ptr_q];
    fifo_empty  = (level_q == '0);
    in_ready    = (level_q != LVL_FULL);
    push        = in_valid & in_ready;
    pop         = !fifo_empty && ((out_state_q == OUT_EMPTY) || out_ready);
    shift_in    = fifo_empty ? 32'h0 : {head.op1, head.op2};
    shift_lines = fifo_empty ? 3'b000 : head.sel;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_op1, in_op2, in_sel};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    out_state_d  = out_state_q;
    out_result_d = out_result_q;
    out_sel_d    = out_sel_q;
    case (out_state_q)
      OUT_EMPTY: begin
        if (pop) begin
          out_result_d = shift_out;
          out_sel_d    = head.sel;
          out_state_d  = OUT_FULL;
        end
      end
      OUT_FULL: begin
        // pop here already implies out_ready, so the register reloads back-to-back.
        if (pop) begin
          out_result_d = shift_out;
          out_sel_d    = head.sel;
        end else if (out_ready) begin
          out_state_d = OUT_EMPTY;
        end
      end
      default: out_state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      out_state_q  <= OUT_EMPTY;
      out_result_q <= 32'h0;
      out_sel_q    <= 3'b000;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      out_state_q  <= out_state_d;
      out_result_q <= out_result_d;
      out_sel_q    <= out_sel_d;
    end
  end

  assign out_valid  = (out_state_q == OUT_FULL);
  assign out_result = out_result_q;
  assign out_sel    = out_sel_q;
  assign fifo_level = level_q;

`ifdef SHIFT_ISSUE_STATS_EN
  logic [15:0] issue_count_q, issue_count_d;

  always_comb begin
    issue_count_d = issue_count_q;
    if (out_valid && out_ready && (issue_count_q != 16'hFFFF)) begin
      issue_count_d = issue_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_count_q <= 16'h0;
    end else begin
      issue_count_q <= issue_count_d;
    end
  end

  assign issue_count = issue_count_q;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - self-checking bench for shift_issue_stage (DEPTH=4).
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_op1;
  logic [15:0] in_op2;
  logic [2:0]  in_sel;
  logic [31:0] shift_in;
  logic [2:0]  shift_lines;
  logic [31:0] shift_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_sel;
  logic [2:0]  fifo_level;
`ifdef SHIFT_ISSUE_STATS_EN
  logic [15:0] issue_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in for shift_unit: swap halves and xor in the select.
  assign shift_out = {shift_in[15:0], shift_in[31:16]} ^ {29'd0, shift_lines};

  shift_issue_stage #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op1      (in_op1),
    .in_op2      (in_op2),
    .in_sel      (in_sel),
    .shift_in    (shift_in),
    .shift_lines (shift_lines),
    .shift_out   (shift_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_sel     (out_sel),
    .fifo_level  (fifo_level)
`ifdef SHIFT_ISSUE_STATS_EN
    ,
    .issue_count (issue_count)
`endif
  );

  typedef struct {
    logic [15:0] op1;
    logic [15:0] op2;
    logic [2:0]  sel;
    logic [31:0] exp_in;
    logic [31:0] exp_res;
  } vec_t;

  vec_t tbl [6];

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
    return {b, a} ^ {29'd0, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int i);
    in_op1 = tbl[i].op1;
    in_op2 = tbl[i].op2;
    in_sel = tbl[i].sel;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [15:0] s_op1 [20];
  logic [15:0] s_op2 [20];
  logic [2:0]  s_sel [20];
  logic [31:0] held_res;
  logic [2:0]  held_sel;
  int          accepted;
  int          got;
  int          first_c;
  int          last_c;
  int          idx;
  logic        acc;

  initial begin
    tbl[0] = '{16'hA5A5, 16'h0003, 3'b010, 32'hA5A50003, 32'h0003A5A7};
    tbl[1] = '{16'h1234, 16'h5678, 3'b111, 32'h12345678, 32'h56781233};
    tbl[2] = '{16'hFFFF, 16'h0000, 3'b000, 32'hFFFF0000, 32'h0000FFFF};
    tbl[3] = '{16'h0000, 16'hFFFF, 3'b101, 32'h0000FFFF, 32'hFFFF0005};
    tbl[4] = '{16'h8001, 16'h7FFE, 3'b011, 32'h80017FFE, 32'h7FFE8002};
    tbl[5] = '{16'hDEAD, 16'hBEEF, 3'b001, 32'hDEADBEEF, 32'hBEEFDEAC};

    // Reset state, with a push offered while reset is held
    rst_n     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(0);
    tick();
    tick();
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_shift_in", shift_in, 32'h0);
    check("rst_shift_lines", 32'(shift_lines), 32'd0);
`ifdef SHIFT_ISSUE_STATS_EN
    check("rst_issue_count", 32'(issue_count), 32'd0);
`endif
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();

    // Mid-operation reset discards buffered entries and the pending result
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      drive(i);
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_level", 32'(fifo_level), 32'd2);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_level", 32'(fifo_level), 32'd0);
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_shift_in", shift_in, 32'h0);
    check("async_rst_out_result", out_result, 32'h0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_stale_out_valid", 32'(out_valid), 32'd0);
    end

    // Single-op latency over the vector table
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      drive(i);
      tick();
      in_valid = 1'b0;
      check("vec_shift_in", shift_in, tbl[i].exp_in);
      check("vec_shift_lines", 32'(shift_lines), 32'(tbl[i].sel));
      check("vec_out_valid_early", 32'(out_valid), 32'd0);
      check("vec_level_1", 32'(fifo_level), 32'd1);
      tick();
      check("vec_out_valid", 32'(out_valid), 32'd1);
      check("vec_out_result", out_result, tbl[i].exp_res);
      check("vec_out_sel", 32'(out_sel), 32'(tbl[i].sel));
      check("vec_level_0", 32'(fifo_level), 32'd0);
    end
    tick();
    check("vec_drained", 32'(out_valid), 32'd0);

    // Fill with out_ready low: 6 offers, 5 accepted, 6th held
    out_ready = 1'b0;
    accepted  = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      drive(accepted);
      acc = in_ready;
      tick();
      if (acc) accepted++;
    end
    check("fill_accepted", 32'(accepted), 32'd5);
    check("fill_level", 32'(fifo_level), 32'd4);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_out_valid", 32'(out_valid), 32'd1);
    held_res = out_result;
    held_sel = out_sel;
    check("fill_out_result", held_res, tbl[0].exp_res);

    // Backpressure: output register frozen
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_out_result", out_result, tbl[0].exp_res);
      check("bp_out_sel", 32'(out_sel), 32'(tbl[0].sel));
      check("bp_level", 32'(fifo_level), 32'd4);
    end

    // Release: full FIFO pops without pushing, then one result per cycle in order
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("rel_out_valid", 32'(out_valid), 32'd1);
      check("rel_out_result", out_result, tbl[k].exp_res);
      check("rel_out_sel", 32'(out_sel), 32'(tbl[k].sel));
      if (k == 1) check("rel_full_pop_no_push", 32'(fifo_level), 32'd3);
      acc = in_valid & in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    check("rel_drained", 32'(out_valid), 32'd0);
    check("rel_sixth_consumed", 32'(in_valid), 32'd0);

    // Streaming: 20 back-to-back random requests with out_ready held high
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s_op1[i] = 16'($urandom);
      s_op2[i] = 16'($urandom);
      s_sel[i] = 3'($urandom_range(0, 7));
    end
    got     = 0;
    first_c = -1;
    last_c  = -1;
    for (int c = 0; c < 24; c++) begin
      in_valid = (c < 20);
      idx      = (c < 20) ? c : 19;
      in_op1   = s_op1[idx];
      in_op2   = s_op2[idx];
      in_sel   = s_sel[idx];
      if (out_valid) begin
        if (got < 20) begin
          check("stream_result", out_result, model(s_op1[got], s_op2[got], s_sel[got]));
          check("stream_sel", 32'(out_sel), 32'(s_sel[got]));
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      check("stream_level_le1", 32'(fifo_level <= 3'd1), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    check("stream_count", 32'(got), 32'd20);
    check("stream_first_cycle", 32'(first_c), 32'd2);
    check("stream_contiguous", 32'(last_c - first_c + 1), 32'd20);

`ifdef SHIFT_ISSUE_STATS_EN
    check("stats_after_stream", 32'(issue_count), 32'd20);
    in_valid = 1'b1;
    in_op1   = 16'h0001;
    in_op2   = 16'h0002;
    in_sel   = 3'b001;
    for (int c = 0; c < 70000; c++) begin
      tick();
    end
    in_valid = 1'b0;
    check("stats_saturate", 32'(issue_count), 32'h0000FFFF);
    tick();
    tick();
    check("stats_hold_sat", 32'(issue_count), 32'h0000FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Upstream issue stage for `shift_unit`. It accepts 16-bit operand pairs and a 3-bit operation select over a valid/ready handshake and buffers them in a small FIFO. It drives the head entry onto `shift_unit`'s packed input and select lines, and registers the returned `shift_out` into an output register with its own valid/ready handshake. It decouples the ALU front end from the consumer of shift results and sustains one operation per cycle.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  stage can accept a request; `level != DEPTH`.
- `in_op1`  in  16  first operand.
- `in_op2`  in  16  second operand.
- `in_sel`  in  3  operation select.
- `shift_in`  out  32  to `shift_unit`: `{head.op1, head.op2}`; 0 when FIFO empty.
- `shift_lines`  out  3  to `shift_unit`: `head.sel`; 0 when FIFO empty.
- `shift_out`  in  32  combinational result from `shift_unit`.
- `out_valid`  out  1  result register holds a result.
- `out_ready`  in  1  consumer accepts result.
- `out_result`  out  32  registered `shift_out`.
- `out_sel`  out  3  select tag of the result.
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `issue_count`  out  16  completed-result counter; present only with `SHIFT_ISSUE_STATS_EN`.

## Operation
- FIFO storage:
  - Each entry is {op1, op2, sel}, 35 bits.
  - Write and read pointers wrap modulo DEPTH; `level` counts 0..DEPTH.
- Push: `in_valid & in_ready`. `in_ready` depends only on `level`, never on `out_ready`. When full, no push is accepted, even in a cycle that also pops.
- Issue (pop): condition is `level != 0 & (!out_valid | out_ready)`.
  - On the edge: `out_result <= shift_out`, `out_sel <= head.sel`, `out_valid <= 1`, read pointer advances.
- Drain: `out_valid & out_ready` with an empty FIFO clears `out_valid` on the edge.
- Simultaneous push and pop: `level` is unchanged, both pointers advance. This is legal at any level below DEPTH.
- Output register states:
  - OUT_EMPTY (`out_valid=0`): goes to OUT_FULL on issue.
  - OUT_FULL (`out_valid=1`):
    - Stays in OUT_FULL while `out_ready=0`, with `out_result`/`out_sel` frozen.
    - With `out_ready=1`: a new issue reloads the register and stays in OUT_FULL; otherwise goes to OUT_EMPTY.
- Ordering: results leave in push order; none are dropped or duplicated.
- `shift_in`/`shift_lines` decode combinationally from the head entry registers and are stable for the whole cycle.

## Timing
- Reset values (asynchronous, while `rst_n=0`):
  - Pointers 0, `level`/`fifo_level` 0.
  - `out_valid` 0, `out_result` 32'h0, `out_sel` 3'b000.
  - `shift_in` 0, `shift_lines` 0.
  - `in_ready` 1; pushes are ignored while reset is held.
  - `issue_count` 0.
- Latency, with the request accepted at edge N:
  - Head is visible on `shift_in`/`shift_lines` in cycle N+1.
  - `out_valid`/`out_result` are visible from edge N+1 (cycle N+2).
- Throughput: one result per cycle with `out_ready=1` continuously.
- Capacity: DEPTH buffered entries plus 1 in the output register.
- Reset mid-operation: all buffered entries and the pending result are discarded. The first post-reset result comes only from a post-reset push.

## Configuration
- `SHIFT_ISSUE_STATS_EN` defined:
  - Adds the `issue_count` port.
  - 16-bit counter increments on every `out_valid & out_ready` edge and saturates at 16'hFFFF.
- Not defined: port and counter are absent. All other behaviour is identical.

## Test plan
- Reset: push 3 entries with `out_ready=0`, then pulse `rst_n=0` → `fifo_level=0`, `out_valid=0`, `shift_in=0`, `out_result=0`; no stale result appears after release.
- Single op: `in_op1=16'hA5A5`, `in_op2=16'h0003`, `in_sel=3'b010` → next cycle `shift_in=32'hA5A50003`, `shift_lines=3'b010`. Following cycle `out_valid=1`, `out_result` equals `shift_out` sampled in the issue cycle, `out_sel=3'b010`.
- Fill (DEPTH=4, `out_ready=0`): offer 6 back-to-back requests → 5 accepted, `fifo_level=4`, `in_ready=0`, 6th held.
- Backpressure: hold `out_ready=0` for 10 cycles → `out_result`/`out_sel` constant. Raise `out_ready` → one result per cycle, in order.
- Streaming: `out_ready=1`, 20 back-to-back random requests → 20 in-order results at one per cycle, pointers wrapping 5 times, `fifo_level` ≤ 1.
- Stats (`SHIFT_ISSUE_STATS_EN`): after streaming, `issue_count=20`. Force 70000 completions → `issue_count=16'hFFFF`.
